shift_frame_arbiter: RTL and testbench

Two-requester controller that shares one serial shift path (the `shift_reg8b` serial-in/parallel-out register) between independent byte sources. It accepts bytes over valid/ready handshakes, arbitrates round-robin, and drives the serial data and shift-enable for exactly one frame of `DATA_W` bits, MSB first. It signals completion with a one-cycle pulse, then inserts a programmable idle gap. It sits directly upstream of the shift register's `sdin` input.

---
 rtl/shift_ctrl_pkg.sv | 21 ++
 rtl/piso_shifter.sv | 29 ++
 rtl/shift_frame_arbiter.sv | 154 +++++++++++++++
 tb/tb_shift_frame_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift-frame arbiter and its serialiser.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } frame_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_GAP    = 1;

  // Bits needed to hold values 0..n-1; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-load, shift-left register exposing its MSB; feeds the serial output.
module piso_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_shift,
  output logic              o_msb
);

  logic [DATA_W-1:0] r_data;

  // NOTE: this is a single word, not a memory, so it is reset to keep o_msb
  // defined from the first cycle; array storage would normally be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[DATA_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[DATA_W-1];

endmodule

// File: rtl/shift_frame_arbiter.sv
// Round-robin arbiter serialising one DATA_W-bit frame (MSB first) from either
// of two valid/ready requesters, followed by a programmable idle gap.
module shift_frame_arbiter
  import shift_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAP    = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              sdin_o,
  output logic              shift_en,
  output logic              grant_id,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;
  localparam int GAP_W = (clog2(GAP + 1) > 0) ? clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  frame_state_t      r_state;
  frame_state_t      w_next_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_last_grant;
  logic              r_grant_id;
  logic              r_sdin;
  logic              r_shift_en;
  logic              r_frame_done;

  logic              w_winner;
  logic              w_any_valid;
  logic              w_handshake;
  logic              w_shift;
  logic              w_sh_msb;
  logic [DATA_W-1:0] w_win_data;
  logic [DATA_W-1:0] w_load_val;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_winner    = 1'b0;
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else if (!req0_valid) begin
      w_winner = 1'b1;
    end
  end

  // Readys are also held low while reset is asserted.
  assign w_handshake = (r_state == S_IDLE) && w_any_valid && rst;
  assign req0_ready  = w_handshake && !w_winner;
  assign req1_ready  = w_handshake &&  w_winner;

  // The MSB leaves directly from the input mux at the handshake edge, so the
  // shifter is preloaded with the remaining bits already aligned to its MSB.
  assign w_win_data = w_winner ? req1_data : req0_data;
  assign w_load_val = {w_win_data[DATA_W-2:0], 1'b0};
  assign w_shift    = (r_state == S_SHIFT) && (r_bit_cnt != '0);

  piso_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_handshake),
    .i_data  (w_load_val),
    .i_shift (w_shift),
    .o_msb   (w_sh_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_handshake) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_bit_cnt == '0) w_next_state = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_sdin       <= 1'b0;
      r_shift_en   <= 1'b0;
      r_frame_done <= 1'b0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_handshake) begin
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
            r_bit_cnt    <= BIT_LOAD;
            r_sdin       <= w_win_data[DATA_W-1];
            r_shift_en   <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_bit_cnt == '0) begin
            r_sdin       <= 1'b0;
            r_shift_en   <= 1'b0;
            r_frame_done <= 1'b1;
            r_gap_cnt    <= GAP_LOAD;
          end else begin
            r_bit_cnt  <= r_bit_cnt - 1'b1;
            r_sdin     <= w_sh_msb;
            r_shift_en <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sdin_o     = r_sdin;
  assign shift_en   = r_shift_en;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_shift_frame_arbiter.sv
// Directed bench for shift_frame_arbiter: one GAP=1 instance and one GAP=0 instance.
module tb_shift_frame_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       r0v = 1'b0, r1v = 1'b0;
  logic [7:0] r0d = 8'h00, r1d = 8'h00;
  logic       r0r, r1r, sdin, sen, gid, busy, fdone;

  logic       z_r0v = 1'b0, z_r1v = 1'b0;
  logic [7:0] z_r0d = 8'h00, z_r1d = 8'h00;
  logic       z_r0r, z_r1r, z_sdin, z_sen, z_gid, z_busy, z_fdone;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sr_model = 8'h00;

  shift_frame_arbiter #(.DATA_W(8), .GAP(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
    .sdin_o(sdin), .shift_en(sen), .grant_id(gid), .busy(busy), .frame_done(fdone)
  );

  shift_frame_arbiter #(.DATA_W(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(z_r0v), .req0_data(z_r0d), .req0_ready(z_r0r),
    .req1_valid(z_r1v), .req1_data(z_r1d), .req1_ready(z_r1r),
    .sdin_o(z_sdin), .shift_en(z_sen), .grant_id(z_gid), .busy(z_busy), .frame_done(z_fdone)
  );

  always #5 clk = ~clk;

  // Downstream shift_reg8b stand-in.
  always @(posedge clk) if (sen) sr_model <= {sr_model[6:0], sdin};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    r0v = 1'b1;
    z_r1v = 1'b1;
    tick();
    tick();
    n_vec++; if (sdin !== 1'b0)  begin n_err++; $display("FAIL reset_sdin: got %b want 0", sdin); end
    n_vec++; if (sen !== 1'b0)   begin n_err++; $display("FAIL reset_shift_en: got %b want 0", sen); end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (fdone !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", fdone); end
    n_vec++; if (gid !== 1'b0)   begin n_err++; $display("FAIL reset_grant_id: got %b want 0", gid); end
    n_vec++; if (r0r !== 1'b0)   begin n_err++; $display("FAIL reset_req0_ready: got %b want 0", r0r); end
    n_vec++; if (z_r1r !== 1'b0) begin n_err++; $display("FAIL reset_gap0_req1_ready: got %b want 0", z_r1r); end
    n_vec++; if (z_busy !== 1'b0) begin n_err++; $display("FAIL reset_gap0_busy: got %b want 0", z_busy); end
    r0v = 1'b0;
    z_r1v = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] v;
    v = 8'hA5;
    r0v = 1'b1; r0d = v;
    #1;
    n_vec++; if (r0r !== 1'b1) begin n_err++; $display("FAIL single_req0_ready: got %b want 1", r0r); end
    n_vec++; if (r1r !== 1'b0) begin n_err++; $display("FAIL single_req1_ready: got %b want 0", r1r); end
    tick();
    r0v = 1'b0; r0d = 8'h00;
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (sen !== 1'b1)      begin n_err++; $display("FAIL single_shift_en[%0d]: got %b want 1", k, sen); end
      n_vec++; if (sdin !== v[7-k])   begin n_err++; $display("FAIL single_sdin[%0d]: got %b want %b", k, sdin, v[7-k]); end
      n_vec++; if (busy !== 1'b1)     begin n_err++; $display("FAIL single_busy[%0d]: got %b want 1", k, busy); end
      n_vec++; if (fdone !== 1'b0)    begin n_err++; $display("FAIL single_early_done[%0d]: got %b want 0", k, fdone); end
      tick();
    end
    n_vec++; if (fdone !== 1'b1)      begin n_err++; $display("FAIL single_frame_done: got %b want 1", fdone); end
    n_vec++; if (sen !== 1'b0)        begin n_err++; $display("FAIL single_shift_en_end: got %b want 0", sen); end
    n_vec++; if (busy !== 1'b1)       begin n_err++; $display("FAIL single_busy_gap: got %b want 1", busy); end
    n_vec++; if (sr_model !== 8'hA5)  begin n_err++; $display("FAIL single_dout: got %h want a5", sr_model); end
    n_vec++; if (gid !== 1'b0)        begin n_err++; $display("FAIL single_grant_id: got %b want 0", gid); end
    tick();
    n_vec++; if (fdone !== 1'b0)      begin n_err++; $display("FAIL single_done_pulse: got %b want 0", fdone); end
    n_vec++; if (busy !== 1'b0)       begin n_err++; $display("FAIL single_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic       g;
    logic [7:0] v;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    r0v = 1'b1; r0d = 8'h0F;
    r1v = 1'b1; r1d = 8'hF0;
    for (int f = 0; f < 4; f++) begin
      g = (f % 2) == 1;
      v = g ? 8'hF0 : 8'h0F;
      #1;
      n_vec++; if (r0r !== !g) begin n_err++; $display("FAIL rr_req0_ready[%0d]: got %b want %b", f, r0r, !g); end
      n_vec++; if (r1r !== g)  begin n_err++; $display("FAIL rr_req1_ready[%0d]: got %b want %b", f, r1r, g); end
      tick();
      for (int k = 0; k < 8; k++) begin
        n_vec++; if (sdin !== v[7-k])    begin n_err++; $display("FAIL rr_sdin[%0d][%0d]: got %b want %b", f, k, sdin, v[7-k]); end
        n_vec++; if (gid !== g)          begin n_err++; $display("FAIL rr_grant_id[%0d]: got %b want %b", f, gid, g); end
        n_vec++; if ((r0r | r1r) !== 1'b0) begin n_err++; $display("FAIL rr_ready_in_shift[%0d]: got %b%b want 00", f, r0r, r1r); end
        tick();
      end
      n_vec++; if (fdone !== 1'b1)       begin n_err++; $display("FAIL rr_frame_done[%0d]: got %b want 1", f, fdone); end
      n_vec++; if ((r0r | r1r) !== 1'b0) begin n_err++; $display("FAIL rr_ready_in_gap[%0d]: got %b%b want 00", f, r0r, r1r); end
      tick();
    end
    r0v = 1'b0;
    r1v = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle_after: got %b want 0", busy); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    int         n_sen;
    logic       exp_sen, exp_fd;
    int         b;
    v = 8'h81;
    n_sen = 0;
    z_r1v = 1'b1; z_r1d = v;
    #1;
    n_vec++; if (z_r1r !== 1'b1) begin n_err++; $display("FAIL b2b_req1_ready: got %b want 1", z_r1r); end
    tick();
    for (int c = 1; c <= 19; c++) begin
      exp_sen = (c >= 1 && c <= 8) || (c >= 10 && c <= 17);
      exp_fd  = (c == 9) || (c == 18);
      b = (c <= 8) ? (8 - c) : (17 - c);
      if (c == 10) z_r1v = 1'b0;
      if (z_sen === 1'b1) n_sen++;
      n_vec++; if (z_sen !== exp_sen) begin n_err++; $display("FAIL b2b_shift_en[T+%0d]: got %b want %b", c, z_sen, exp_sen); end
      n_vec++; if (z_fdone !== exp_fd) begin n_err++; $display("FAIL b2b_frame_done[T+%0d]: got %b want %b", c, z_fdone, exp_fd); end
      if (exp_sen) begin
        n_vec++; if (z_sdin !== v[b]) begin n_err++; $display("FAIL b2b_sdin[T+%0d]: got %b want %b", c, z_sdin, v[b]); end
      end
      if (c == 9) begin
        #1;
        n_vec++; if (z_r1r !== 1'b1) begin n_err++; $display("FAIL b2b_second_ready: got %b want 1", z_r1r); end
      end
      tick();
    end
    n_vec++; if (n_sen != 16) begin n_err++; $display("FAIL b2b_shift_count: got %0d want 16", n_sen); end
  endtask

  task automatic test_data_hold();
    logic [7:0] v;
    v = 8'h3C;
    r0v = 1'b1; r0d = v;
    #1;
    n_vec++; if (r0r !== 1'b1) begin n_err++; $display("FAIL hold_req0_ready: got %b want 1", r0r); end
    tick();
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin r0v = 1'b0; r0d = 8'h00; end
      n_vec++; if (sdin !== v[7-k]) begin n_err++; $display("FAIL hold_sdin[%0d]: got %b want %b", k, sdin, v[7-k]); end
      tick();
    end
    n_vec++; if (sr_model !== 8'h3C) begin n_err++; $display("FAIL hold_dout: got %h want 3c", sr_model); end
    n_vec++; if (fdone !== 1'b1)     begin n_err++; $display("FAIL hold_frame_done: got %b want 1", fdone); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    v = 8'hC3;
    r1v = 1'b1; r1d = 8'hFF;
    #1;
    n_vec++; if (r1r !== 1'b1) begin n_err++; $display("FAIL rmid_req1_ready: got %b want 1", r1r); end
    tick();
    tick(); tick(); tick();
    n_vec++; if (gid !== 1'b1) begin n_err++; $display("FAIL rmid_pre_grant: got %b want 1", gid); end
    n_vec++; if (sen !== 1'b1) begin n_err++; $display("FAIL rmid_pre_shift_en: got %b want 1", sen); end
    rst = 1'b0;
    r0v = 1'b1; r0d = v;
    #1;
    n_vec++; if (sdin !== 1'b0)  begin n_err++; $display("FAIL rmid_sdin: got %b want 0", sdin); end
    n_vec++; if (sen !== 1'b0)   begin n_err++; $display("FAIL rmid_shift_en: got %b want 0", sen); end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_vec++; if (fdone !== 1'b0) begin n_err++; $display("FAIL rmid_frame_done: got %b want 0", fdone); end
    n_vec++; if (gid !== 1'b0)   begin n_err++; $display("FAIL rmid_grant_id: got %b want 0", gid); end
    n_vec++; if ((r0r | r1r) !== 1'b0) begin n_err++; $display("FAIL rmid_readys: got %b%b want 00", r0r, r1r); end
    tick();
    n_vec++; if (fdone !== 1'b0) begin n_err++; $display("FAIL rmid_frame_done_held: got %b want 0", fdone); end
    rst = 1'b1;
    #1;
    n_vec++; if (r0r !== 1'b1) begin n_err++; $display("FAIL rmid_after_req0_ready: got %b want 1", r0r); end
    n_vec++; if (r1r !== 1'b0) begin n_err++; $display("FAIL rmid_after_req1_ready: got %b want 0", r1r); end
    tick();
    r0v = 1'b0; r1v = 1'b0;
    n_vec++; if (gid !== 1'b0) begin n_err++; $display("FAIL rmid_after_grant: got %b want 0", gid); end
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (sdin !== v[7-k]) begin n_err++; $display("FAIL rmid_sdin[%0d]: got %b want %b", k, sdin, v[7-k]); end
      tick();
    end
    n_vec++; if (fdone !== 1'b1)     begin n_err++; $display("FAIL rmid_new_done: got %b want 1", fdone); end
    n_vec++; if (sr_model !== 8'hC3) begin n_err++; $display("FAIL rmid_dout: got %h want c3", sr_model); end
    tick();
  endtask

  task automatic test_valid_in_busy();
    r0v = 1'b1; r0d = 8'h55;
    #1;
    n_vec++; if (r0r !== 1'b1) begin n_err++; $display("FAIL busyv_req0_ready: got %b want 1", r0r); end
    tick();
    r0v = 1'b0;
    r1v = 1'b1; r1d = 8'hAA;
    for (int c = 1; c <= 9; c++) begin
      #1;
      n_vec++; if ((r0r | r1r) !== 1'b0) begin n_err++; $display("FAIL busyv_readys[T+%0d]: got %b%b want 00", c, r0r, r1r); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busyv_busy[T+%0d]: got %b want 1", c, busy); end
      tick();
    end
    #1;
    n_vec++; if (r1r !== 1'b1)  begin n_err++; $display("FAIL busyv_idle_ready: got %b want 1", r1r); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busyv_idle_busy: got %b want 0", busy); end
    tick();
    r1v = 1'b0;
    n_vec++; if (gid !== 1'b1) begin n_err++; $display("FAIL busyv_grant: got %b want 1", gid); end
    n_vec++; if (sen !== 1'b1) begin n_err++; $display("FAIL busyv_shift_en: got %b want 1", sen); end
    n_vec++; if (sdin !== 1'b1) begin n_err++; $display("FAIL busyv_first_bit: got %b want 1", sdin); end
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_data_hold();
    test_reset_mid();
    test_valid_in_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
